// File: rtl/riscv_pkg.sv
// Shared types and sizing helpers for the writeback scoreboard.
package riscv_pkg;

  localparam int WIDTH_DEF    = 32;
  localparam int REG_ADDR_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sb_state_t;

  // Counter width able to hold 0..depth inclusive.
  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO of expected {rd,value} entries with a combinational head.
module riscv_sync_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = REG_ADDR_DEF + WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [cw_of(DEPTH)-1:0]  count
);

  localparam int CW = cw_of(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/riscv_wb_scoreboard.sv
// Compares the core's retired register writebacks, in order, against a preloaded list
// of expected {rd,value} pairs and reports match/error counts, first failure and timeout.
module riscv_wb_scoreboard
  import riscv_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int DEPTH    = 16,
  parameter int REG_ADDR = REG_ADDR_DEF,
  parameter int TIMEOUT  = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        exp_valid,
  output logic                        exp_ready,
  input  logic [REG_ADDR-1:0]         exp_addr,
  input  logic [WIDTH-1:0]            exp_data,
  input  logic                        start,
  input  logic                        wb_valid,
  input  logic [REG_ADDR-1:0]         wb_addr,
  input  logic [WIDTH-1:0]            wb_data,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        timeout,
  output logic [cw_of(DEPTH)-1:0]     match_count,
  output logic [cw_of(DEPTH)-1:0]     err_count,
  output logic [cw_of(DEPTH)-1:0]     fail_idx,
  output logic [REG_ADDR+WIDTH-1:0]   fail_exp,
  output logic [REG_ADDR+WIDTH-1:0]   fail_data
);

  localparam int CW = cw_of(DEPTH);
  localparam int DW = REG_ADDR + WIDTH;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  sb_state_t     state_reg, state_next;
  logic [DW-1:0] head;
  logic          full, empty;
  logic [CW-1:0] fifo_count;
  logic          push, pop, wb_acc, hit, tmo_expire;
  logic [TW-1:0] tmo_cnt_reg;
  logic [CW-1:0] match_reg, err_reg, cmp_idx_reg, fail_idx_reg;
  logic [DW-1:0] fail_exp_reg, fail_data_reg;
  logic          timeout_reg;

  // Held low while reset is asserted so every output reads 0 during reset.
  assign exp_ready  = rst && (state_reg == ST_IDLE) && !full;
  assign push       = exp_valid && exp_ready;
  assign wb_acc     = wb_valid && (wb_addr != '0);
  assign pop        = (state_reg == ST_RUN) && wb_acc;
  assign hit        = ({wb_addr, wb_data} == head);
  assign tmo_expire = (state_reg == ST_RUN) && !wb_acc && (tmo_cnt_reg == TMO_LAST);

  riscv_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .push      (push),
    .push_data ({exp_addr, exp_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = (push || !empty) ? ST_RUN : ST_DONE;
      ST_RUN: begin
        if (pop && (fifo_count == CW'(1))) state_next = ST_DONE;
        else if (tmo_expire)               state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_reg   <= '0;
      match_reg     <= '0;
      err_reg       <= '0;
      cmp_idx_reg   <= '0;
      fail_idx_reg  <= '0;
      fail_exp_reg  <= '0;
      fail_data_reg <= '0;
      timeout_reg   <= 1'b0;
    end else if (clear) begin
      tmo_cnt_reg   <= '0;
      match_reg     <= '0;
      err_reg       <= '0;
      cmp_idx_reg   <= '0;
      fail_idx_reg  <= '0;
      fail_exp_reg  <= '0;
      fail_data_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      if (state_reg == ST_RUN) tmo_cnt_reg <= wb_acc ? '0 : tmo_cnt_reg + 1'b1;
      else                     tmo_cnt_reg <= '0;
      if (pop) begin
        cmp_idx_reg <= cmp_idx_reg + 1'b1;
        if (hit) begin
          match_reg <= match_reg + 1'b1;
        end else begin
          err_reg <= err_reg + 1'b1;
          // Only the first mismatch is kept; later ones just count.
          if (err_reg == '0) begin
            fail_idx_reg  <= cmp_idx_reg;
            fail_exp_reg  <= head;
            fail_data_reg <= {wb_addr, wb_data};
          end
        end
      end
      if (tmo_expire) timeout_reg <= 1'b1;
    end
  end

  assign busy        = (state_reg == ST_RUN);
  assign done        = (state_reg == ST_DONE);
  assign pass        = done && (err_reg == '0) && !timeout_reg;
  assign timeout     = timeout_reg;
  assign match_count = match_reg;
  assign err_count   = err_reg;
  assign fail_idx    = fail_idx_reg;
  assign fail_exp    = fail_exp_reg;
  assign fail_data   = fail_data_reg;

endmodule

// File: tb/tb_riscv_wb_scoreboard.sv
// Bench for riscv_wb_scoreboard: expected run results are queued at issue time and
// checked by a monitor when done rises; directed scenarios plus randomized runs.
module tb_riscv_wb_scoreboard;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 16;
  localparam int RA      = 5;
  localparam int TIMEOUT = 1024;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int DW      = RA + WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic exp_valid = 1'b0;
  logic [RA-1:0] exp_addr = '0;
  logic [WIDTH-1:0] exp_data = '0;
  logic start = 1'b0;
  logic wb_valid = 1'b0;
  logic [RA-1:0] wb_addr = '0;
  logic [WIDTH-1:0] wb_data = '0;
  logic exp_ready, busy, done, pass, timeout;
  logic [CW-1:0] match_count, err_count, fail_idx;
  logic [DW-1:0] fail_exp, fail_data;

  riscv_wb_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REG_ADDR(RA), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr), .exp_data(exp_data),
    .start(start), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .match_count(match_count), .err_count(err_count), .fail_idx(fail_idx),
    .fail_exp(fail_exp), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            tmo;
    int            mc;
    int            ec;
    int            fidx;
    logic [DW-1:0] fexp;
    logic [DW-1:0] fdata;
  } res_t;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  res_t          res_q[$];
  int checks = 0;
  int errors = 0;
  bit done_q = 1'b0;

  logic [WIDTH-1:0] s1_vals [14] = '{32'd10, 32'd10, 32'd20, 32'd1, 32'd5, 32'd40, 32'd4,
                                     32'd21, 32'd17, 32'hFFFFFFE2, 32'd5, 32'd20,
                                     32'hFFFFFFFF, 32'hFFFFFFFF};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: the i-th non-x0 writeback is judged against the i-th accepted entry;
  // if the writebacks run out before the entries, the run ends by timeout.
  function automatic res_t model();
    res_t r = '{default: 0};
    int   n = exp_q.size();
    int   k;
    r.tmo = (obs_q.size() < n);
    k = r.tmo ? obs_q.size() : n;
    for (int i = 0; i < k; i++) begin
      if (obs_q[i] == exp_q[i]) begin
        r.mc++;
      end else begin
        if (r.ec == 0) begin
          r.fidx  = i;
          r.fexp  = exp_q[i];
          r.fdata = obs_q[i];
        end
        r.ec++;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    obs_q.delete();
    chk("clear_done", done, 0);
    chk("clear_busy", busy, 0);
    chk("clear_match", match_count, 0);
    chk("clear_err", err_count, 0);
    chk("clear_ready", exp_ready, 1);
  endtask

  task automatic push_entry(input logic [RA-1:0] a, input logic [WIDTH-1:0] d,
                            input bit with_start, input bit rdy_req);
    exp_valid = 1'b1;
    exp_addr  = a;
    exp_data  = d;
    start     = with_start;
    chk("exp_ready", exp_ready, rdy_req);
    tick();
    exp_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, exp_q.size() > 0);
  endtask

  task automatic wb_cycle(input bit v, input logic [RA-1:0] a, input logic [WIDTH-1:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("done_wait", done, 1);
  endtask

  initial begin
    int   cyc;
    res_t r;

    fork
      begin : monitor
        res_t m;
        forever begin
          @(negedge clk);
          if (done && !done_q) begin
            if (res_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: got done=1, expected no completion");
            end else begin
              m = res_q.pop_front();
              chk("pass", pass, (m.ec == 0) && !m.tmo);
              chk("timeout", timeout, m.tmo);
              chk("match_count", match_count, m.mc);
              chk("err_count", err_count, m.ec);
              chk("fail_idx", fail_idx, m.fidx);
              chk("fail_exp", fail_exp, m.fexp);
              chk("fail_data", fail_data, m.fdata);
              $display("run result: pass=%0b timeout=%0b match=%0d err=%0d fail_idx=%0d",
                       pass, timeout, match_count, err_count, fail_idx);
            end
          end
          done_q = done;
        end
      end
    join_none

    // Reset state
    tick();
    #1;
    chk("rst_ready", exp_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_match", match_count, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", exp_ready, 1);

    // Scenarios 1 and 2: 14-entry program, clean then with two corrupted writebacks
    for (int sc = 0; sc < 2; sc++) begin
      do_clear();
      for (int i = 0; i < 14; i++) begin
        push_entry(RA'(i + 1), s1_vals[i], 1'b0, 1'b1);
        exp_q.push_back({RA'(i + 1), s1_vals[i]});
      end
      foreach (exp_q[i]) obs_q.push_back(exp_q[i]);
      if (sc == 1) begin
        obs_q[9]  = {RA'(10), 32'hFFFFFFE0};
        obs_q[11] = {RA'(12), 32'd21};
      end
      res_q.push_back(model());
      do_start();
      foreach (obs_q[i]) wb_cycle(1'b1, obs_q[i][DW-1:WIDTH], obs_q[i][WIDTH-1:0]);
      chk("done_latency", done, 1);
      $display("scenario %0d: 14 entries compared", sc + 1);
    end

    // Scenario 3: overfill, then 16 matches with an x0 write in the middle
    do_clear();
    for (int i = 0; i < 17; i++) begin
      push_entry(RA'(i + 1), WIDTH'(i * 7 + 3), 1'b0, i < DEPTH);
      if (i < DEPTH) exp_q.push_back({RA'(i + 1), WIDTH'(i * 7 + 3)});
    end
    foreach (exp_q[i]) obs_q.push_back(exp_q[i]);
    res_q.push_back(model());
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 8) begin
        wb_cycle(1'b1, '0, 32'hDEADBEEF);
        chk("x0_ignored", match_count, 8);
      end
      wb_cycle(1'b1, obs_q[i][DW-1:WIDTH], obs_q[i][WIDTH-1:0]);
    end
    chk("done_latency_full", done, 1);
    $display("scenario 3: full FIFO with x0 interleave");

    // Scenario 4: timeout with no writebacks
    do_clear();
    for (int i = 0; i < 3; i++) begin
      push_entry(RA'(i + 3), WIDTH'(i), 1'b0, 1'b1);
      exp_q.push_back({RA'(i + 3), WIDTH'(i)});
    end
    res_q.push_back(model());
    do_start();
    wait_done(TIMEOUT + 16, cyc);
    chk("timeout_cycles", cyc, TIMEOUT);
    $display("scenario 4: timeout after %0d cycles", cyc);

    // Scenario 5: reset during RUN after 5 compares
    do_clear();
    for (int i = 0; i < 10; i++) begin
      push_entry(RA'(i + 1), WIDTH'(100 + i), 1'b0, 1'b1);
      exp_q.push_back({RA'(i + 1), WIDTH'(100 + i)});
    end
    do_start();
    for (int i = 0; i < 5; i++) wb_cycle(1'b1, RA'(i + 1), WIDTH'(100 + i));
    chk("mid_run_match", match_count, 5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_pass", pass, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_match", match_count, 0);
    chk("arst_err", err_count, 0);
    chk("arst_fail_idx", fail_idx, 0);
    chk("arst_fail_exp", fail_exp, 0);
    chk("arst_fail_data", fail_data, 0);
    chk("arst_ready", exp_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    obs_q.delete();
    chk("rel_ready", exp_ready, 1);
    chk("rel_busy", busy, 0);
    $display("scenario 5: asynchronous reset mid-run");

    // Scenario 6: start with the FIFO left empty by reset
    res_q.push_back(model());
    do_start();
    chk("empty_start_done", done, 1);
    wb_cycle(1'b1, RA'(4), WIDTH'(9));
    chk("done_hold_match", match_count, 0);
    do_clear();
    $display("scenario 6: empty start then clear");

    // Randomized runs
    for (int t = 0; t < 24; t++) begin
      int n;
      bit joint;
      do_clear();
      n = $urandom_range(0, DEPTH);
      for (int i = 0; i < n; i++) begin
        logic [WIDTH-1:0] d;
        d = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
        exp_q.push_back({RA'($urandom_range(1, 31)), d});
      end
      foreach (exp_q[i]) begin
        logic [DW-1:0] o;
        o = exp_q[i];
        case ($urandom_range(0, 7))
          0: o[WIDTH-1:0] = o[WIDTH-1:0] ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
          1: o[DW-1:WIDTH] = RA'((int'(o[DW-1:WIDTH]) % 31) + 1);
          default: ;
        endcase
        obs_q.push_back(o);
      end
      r = model();
      res_q.push_back(r);
      joint = (n > 0) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < n; i++)
        push_entry(exp_q[i][DW-1:WIDTH], exp_q[i][WIDTH-1:0], joint && (i == n - 1), 1'b1);
      if (joint) chk("busy_joint_start", busy, 1);
      else       do_start();
      foreach (obs_q[i]) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) wb_cycle($urandom_range(0, 1) == 1, '0, WIDTH'($urandom));
        wb_cycle(1'b1, obs_q[i][DW-1:WIDTH], obs_q[i][WIDTH-1:0]);
      end
      chk("rand_done_latency", done, 1);
      wb_cycle(1'b1, RA'($urandom_range(1, 31)), WIDTH'($urandom));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rand_hold_done", done, 1);
      chk("rand_hold_match", match_count, r.mc);
      chk("rand_hold_err", err_count, r.ec);
      $display("random run %0d: entries=%0d joint_start=%0b match=%0d err=%0d",
               t, n, joint, r.mc, r.ec);
    end

    repeat (3) tick();
    chk("pending_results", res_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
